// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game sequencer for the movement datapath.
//
// Steps through attract (IDLE), READY, PLAY, PAUSED, DEATH, level CLEAR and
// GAME_OVER phases from button pulses and gameplay event pulses. It drives the
// shared pause / restart_actors signals and tracks lives, level and remaining dots.
//
// Optional feature macro: EXTRA_LIFE_EN -- when defined, a level clear also awards
// one life (saturating at 7). Sequencing and timing are identical either way.
//
// Ports:
//   clk            in   system clock (25 MHz)
//   reset          in   asynchronous, active-high reset
//   start          in   one-cycle pulse, debounced start button
//   pause_btn      in   one-cycle pulse, toggles user pause
//   dot_eaten      in   one-cycle pulse per dot consumed
//   caught         in   level, pacman/ghost overlap this cycle
//   pause          out  freeze to all movement blocks (low only in PLAY)
//   restart_actors out  one-cycle pulse on the first READY cycle
//   lives          out  remaining lives
//   level          out  current level, 1..15
//   dots_left      out  dots remaining this level
//   state          out  IDLE=0 READY=1 PLAY=2 PAUSED=3 DEATH=4 CLEAR=5 GAME_OVER=6
//   game_over      out  high only in GAME_OVER
// All outputs are registered.

module game_flow_controller #(
  parameter int unsigned READY_CYCLES = 50_000_000,
  parameter int unsigned DEATH_CYCLES = 37_500_000,
  parameter int unsigned CLEAR_CYCLES = 50_000_000,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned TOTAL_DOTS   = 244
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_btn,
  input  logic       dot_eaten,
  input  logic       caught,
  output logic       pause,
  output logic       restart_actors,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic [8:0] dots_left,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReady    = 3'd1,
    StPlay     = 3'd2,
    StPaused   = 3'd3,
    StDeath    = 3'd4,
    StClear    = 3'd5,
    StGameOver = 3'd6
  } state_e;

  // Expiry compares against N-1 so each timed phase lasts exactly N cycles.
  localparam logic [31:0] ReadyLast = READY_CYCLES - 1;
  localparam logic [31:0] DeathLast = DEATH_CYCLES - 1;
  localparam logic [31:0] ClearLast = CLEAR_CYCLES - 1;
  localparam logic [2:0]  LivesInit = 3'(LIVES_INIT);
  localparam logic [8:0]  DotsInit  = 9'(TOTAL_DOTS);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  lives_q, lives_d;
  logic [3:0]  level_q, level_d;
  logic [8:0]  dots_q, dots_d;
  logic        pause_q, pause_d;
  logic        restart_q, restart_d;
  logic        game_over_q, game_over_d;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    dots_d  = dots_q;
    timer_d = timer_q;

    case (state_q)
      StIdle, StGameOver: begin
        if (start) begin
          state_d = StReady;
          lives_d = LivesInit;
          level_d = 4'd1;
          dots_d  = DotsInit;
        end
      end
      StReady: begin
        if (timer_q == ReadyLast) state_d = StPlay;
      end
      StPlay: begin
        if (dot_eaten && dots_q != 9'd0) dots_d = dots_q - 9'd1;
        // Eating the last dot outranks a simultaneous catch or pause request.
        if (dot_eaten && dots_q == 9'd1) state_d = StClear;
        else if (caught)                 state_d = StDeath;
        else if (pause_btn)              state_d = StPaused;
      end
      StPaused: begin
        if (pause_btn) state_d = StPlay;
      end
      StDeath: begin
        if (timer_q == DeathLast) begin
          if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = StGameOver;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = StReady;
          end
        end
      end
      StClear: begin
        if (timer_q == ClearLast) begin
          level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
          dots_d  = DotsInit;
`ifdef EXTRA_LIFE_EN
          lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
`else
          lives_d = lives_q;
`endif
          state_d = StReady;
        end
      end
      default: state_d = StIdle;  // unused encoding recovers to attract mode
    endcase

    // Timer restarts on every state entry and only runs in timed phases.
    if (state_d != state_q) begin
      timer_d = 32'd0;
    end else if (state_q == StReady || state_q == StDeath || state_q == StClear) begin
      timer_d = timer_q + 32'd1;
    end

    pause_d     = (state_d != StPlay);
    restart_d   = (state_d == StReady) && (state_q != StReady);
    game_over_d = (state_d == StGameOver);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= 32'd0;
      lives_q     <= LivesInit;
      level_q     <= 4'd1;
      dots_q      <= DotsInit;
      pause_q     <= 1'b1;
      restart_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      dots_q      <= dots_d;
      pause_q     <= pause_d;
      restart_q   <= restart_d;
      game_over_q <= game_over_d;
    end
  end

  assign state          = state_q;
  assign lives          = lives_q;
  assign level          = level_q;
  assign dots_left      = dots_q;
  assign pause          = pause_q;
  assign restart_actors = restart_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: a stimulus process drives one input set
// per clock, advances a phase/countdown reference model and queues the expected
// outputs; a monitor pops and compares them one cycle later.

module tb_game_flow_controller;

  localparam int ReadyN = 4;
  localparam int DeathN = 6;
  localparam int ClearN = 5;
  localparam int LivesN = 2;
  localparam int DotsN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause_btn = 1'b0;
  logic       dot_eaten = 1'b0;
  logic       caught = 1'b0;
  logic       pause;
  logic       restart_actors;
  logic [2:0] lives;
  logic [3:0] level;
  logic [8:0] dots_left;
  logic [2:0] state;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_flow_controller #(
    .READY_CYCLES(ReadyN),
    .DEATH_CYCLES(DeathN),
    .CLEAR_CYCLES(ClearN),
    .LIVES_INIT  (LivesN),
    .TOTAL_DOTS  (DotsN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause_btn     (pause_btn),
    .dot_eaten     (dot_eaten),
    .caught        (caught),
    .pause         (pause),
    .restart_actors(restart_actors),
    .lives         (lives),
    .level         (level),
    .dots_left     (dots_left),
    .state         (state),
    .game_over     (game_over)
  );

  typedef struct {
    int st;
    int ps;
    int rs;
    int lv;
    int lvl;
    int dots;
    int go;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phase name plus a countdown of cycles left in a timed phase.
  int m_phase = 0;
  int m_left  = 0;
  int m_lives = LivesN;
  int m_level = 1;
  int m_dots  = DotsN;
  int m_restart = 0;

  function automatic void new_game();
    m_lives = LivesN;
    m_level = 1;
    m_dots  = DotsN;
  endfunction

  function automatic void model_step(bit rst, bit st, bit pb, bit de, bit ca);
    int nxt;
    m_restart = 0;
    if (rst) begin
      m_phase = 0;
      new_game();
      return;
    end
    nxt = m_phase;
    case (m_phase)
      0, 6: if (st) begin new_game(); nxt = 1; end
      1: begin m_left--; if (m_left == 0) nxt = 2; end
      2: begin
        if (de && m_dots == 1) begin
          m_dots = 0;
          nxt = 5;
        end else begin
          if (de && m_dots > 0) m_dots--;
          if (ca) nxt = 4;
          else if (pb) nxt = 3;
        end
      end
      3: if (pb) nxt = 2;
      4: begin
        m_left--;
        if (m_left == 0) begin
          if (m_lives <= 1) begin m_lives = 0; nxt = 6; end
          else begin m_lives--; nxt = 1; end
        end
      end
      5: begin
        m_left--;
        if (m_left == 0) begin
          if (m_level < 15) m_level++;
          m_dots = DotsN;
`ifdef EXTRA_LIFE_EN
          if (m_lives < 7) m_lives++;
`endif
          nxt = 1;
        end
      end
      default: nxt = 0;
    endcase
    if (nxt != m_phase) begin
      if (nxt == 1) begin m_restart = 1; m_left = ReadyN; end
      if (nxt == 4) m_left = DeathN;
      if (nxt == 5) m_left = ClearN;
    end
    m_phase = nxt;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Drive one input set for the next rising edge and queue the expected outcome.
  task automatic cyc(input bit rst, input bit st, input bit pb, input bit de, input bit ca);
    exp_t e;
    bit   was_reset;
    @(posedge clk);
    #2;
    was_reset = reset;
    reset     = rst;
    start     = st;
    pause_btn = pb;
    dot_eaten = de;
    caught    = ca;
    model_step(rst, st, pb, de, ca);
    e.st   = m_phase;
    e.ps   = (m_phase != 2) ? 1 : 0;
    e.rs   = m_restart;
    e.lv   = m_lives;
    e.lvl  = m_level;
    e.dots = m_dots;
    e.go   = (m_phase == 6) ? 1 : 0;
    exp_q.push_back(e);
    if (rst && !was_reset) begin
      // Reset is asynchronous: outputs must drop to reset values before any edge.
      #1;
      chk("async_reset_state", int'(state), 0);
      chk("async_reset_pause", int'(pause), 1);
      chk("async_reset_restart", int'(restart_actors), 0);
      chk("async_reset_lives", int'(lives), LivesN);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(state), e.st);
        chk("pause", int'(pause), e.ps);
        chk("restart_actors", int'(restart_actors), e.rs);
        chk("lives", int'(lives), e.lv);
        chk("level", int'(level), e.lvl);
        chk("dots_left", int'(dots_left), e.dots);
        chk("game_over", int'(game_over), e.go);
      end
    end
  end

  initial begin
    bit ca_lvl;
    // Scenario 1: reset, start, READY for 4 cycles, then PLAY.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0, 0);
    idle(5);
    // Scenario 2: clear the level.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    idle(1);
    cyc(0, 0, 0, 1, 0);
    idle(6);
    idle(5);
    // Scenario 3: two deaths down to game over, then a new game.
    cyc(0, 0, 0, 0, 1);
    idle(7);
    idle(5);
    cyc(0, 0, 0, 0, 1);
    idle(7);
    cyc(0, 0, 0, 0, 1);  // ignored in GAME_OVER
    cyc(0, 1, 0, 0, 0);
    idle(5);
    // Scenario 4: last dot and catch together -> CLEAR.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    idle(6);
    idle(5);
    // Scenario 5: pause freezes dots and lives.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    // Scenario 6: reset in the middle of DEATH, then start ignored in PLAY.
    cyc(0, 0, 0, 0, 1);
    idle(3);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(5);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);  // pause with a still-held catch later
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);  // back to PLAY with caught high
    cyc(0, 0, 0, 0, 1);  // DEATH fires again
    idle(8);

    // Randomized phase.
    ca_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ca_lvl = ~ca_lvl;
      cyc(($urandom_range(0, 399) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 2) == 0),
          ca_lvl && ($urandom_range(0, 3) == 0));
    end
    cyc(0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
